// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the
// per-stage enable/flush bundle produced by the priority logic.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic [0:0] {
    StRun,
    StMulti
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
  } stage_ctrl_t;

  // Free-running pipeline: every stage advances, nothing is squashed.
  function automatic stage_ctrl_t ctrl_run();
    stage_ctrl_t c;
    c             = '0;
    c.pc_en       = 1'b1;
    c.ifid_en     = 1'b1;
    c.idex_en     = 1'b1;
    c.exmem_en    = 1'b1;
    c.memwb_en    = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decoder/memory-status inputs and stage-control outputs of the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_AW = pipe_ctrl_pkg::REG_AW_DEF,
  parameter int unsigned CNT_W  = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [1:0]        id_rs_use;
  logic [REG_AW-1:0] id_rd;
  logic              id_memread;
  logic              id_multi;
  logic              ex_branch_taken;
  logic              im_stall;
  logic              dm_stall;
  logic              perf_clr;

  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_en;
  logic              idex_flush;
  logic              exmem_en;
  logic              exmem_flush;
  logic              memwb_en;
  logic              busy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs_use, id_rd, id_memread, id_multi,
           ex_branch_taken, im_stall, dm_stall, perf_clr,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs_use, id_rd, id_memread, id_multi,
           ex_branch_taken, im_stall, dm_stall, perf_clr,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that outranks increment.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: load-use, taken branch, memory
// waits and multi-cycle EX ops, with saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int unsigned CntW = 5;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_memread_q, ex_memread_d;

  stage_ctrl_t ctrl;
  logic        load_use;
  logic        flush_evt;

  always_comb begin
    load_use = ex_memread_q && (ex_rd_q != '0) && bus.id_valid &&
               ((bus.id_rs_use[0] && (bus.id_rs1 == ex_rd_q)) ||
                (bus.id_rs_use[1] && (bus.id_rs2 == ex_rd_q)));
  end

  // First match wins; the order below is the hazard priority.
  always_comb begin
    ctrl      = ctrl_run();
    flush_evt = 1'b0;
    if (bus.dm_stall) begin
      ctrl = '0;
    end else if ((state_q == StMulti) || (bus.ex_branch_taken && bus.im_stall)) begin
      ctrl.pc_en       = 1'b0;
      ctrl.ifid_en     = 1'b0;
      ctrl.idex_en     = 1'b0;
      ctrl.exmem_flush = 1'b1;
    end else if (bus.ex_branch_taken) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
      flush_evt       = 1'b1;
    end else if (load_use) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_en    = 1'b0;
      ctrl.idex_flush = 1'b1;
    end else if (bus.im_stall) begin
      ctrl.pc_en      = 1'b0;
      ctrl.ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StRun: begin
        if (ctrl.idex_en && !ctrl.idex_flush && bus.id_valid && bus.id_multi &&
            (MUL_LAT > 1)) begin
          state_d = StMulti;
          cnt_d   = CntW'(MUL_LAT - 1);
        end
      end
      StMulti: begin
        if (!bus.dm_stall) begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Shadow of the ID/EX destination, used only for load-use detection.
  always_comb begin
    ex_rd_d      = ex_rd_q;
    ex_memread_d = ex_memread_q;
    if (ctrl.idex_en) begin
      if (ctrl.idex_flush || !bus.id_valid) begin
        ex_rd_d      = '0;
        ex_memread_d = 1'b0;
      end else begin
        ex_rd_d      = bus.id_rd;
        ex_memread_d = bus.id_memread;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      cnt_q        <= '0;
      ex_rd_q      <= '0;
      ex_memread_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ex_rd_q      <= ex_rd_d;
      ex_memread_q <= ex_memread_d;
    end
  end

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ifid_en     = ctrl.ifid_en;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_en     = ctrl.idex_en;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.exmem_en    = ctrl.exmem_en;
  assign bus.exmem_flush = ctrl.exmem_flush;
  assign bus.memwb_en    = ctrl.memwb_en;
  assign bus.busy        = (state_q == StMulti);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (!ctrl.pc_en),
    .clr_i (bus.perf_clr),
    .cnt_o (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush_evt),
    .clr_i (bus.perf_clr),
    .cnt_o (bus.flush_cnt)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int unsigned RAW  = 5;
  localparam int unsigned LAT  = 4;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(RAW), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.REG_AW(RAW), .MUL_LAT(LAT), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [8:0] ctrl;
    int         stall;
    int         flush;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state: frozen cycles still owed to a multi-cycle op, the
  // instruction sitting in EX, and the two event tallies.
  int m_frozen, m_ex_rd, m_stall, m_flush;
  bit m_ex_mem;

  task automatic model_reset();
    m_frozen = 0; m_ex_rd = 0; m_ex_mem = 1'b0; m_stall = 0; m_flush = 0;
  endtask

  task automatic chk(input string name, input int c, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0b required=%0b", name, c, got, exp);
    end
  endtask

  function automatic logic [8:0] dut_ctrl();
    return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
            bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.busy};
  endfunction

  task automatic drive(input bit v, input int rs1, input int rs2, input bit [1:0] use_,
                       input int rd, input bit mr, input bit mu, input bit br,
                       input bit im, input bit dm, input bit clr);
    bus.id_valid = v; bus.id_rs1 = RAW'(rs1); bus.id_rs2 = RAW'(rs2);
    bus.id_rs_use = use_; bus.id_rd = RAW'(rd); bus.id_memread = mr;
    bus.id_multi = mu; bus.ex_branch_taken = br; bus.im_stall = im;
    bus.dm_stall = dm; bus.perf_clr = clr;
  endtask

  task automatic step(input bit v, input int rs1, input int rs2, input bit [1:0] use_,
                      input int rd, input bit mr, input bit mu, input bit br,
                      input bit im, input bit dm, input bit clr);
    bit lu, pc, ie, ifl, xe, xf, me, mf, we, fev;
    exp_t e;
    @(posedge clk);
    #1;
    drive(v, rs1, rs2, use_, rd, mr, mu, br, im, dm, clr);
    lu = m_ex_mem && (m_ex_rd != 0) && v &&
         ((use_[0] && rs1 == m_ex_rd) || (use_[1] && rs2 == m_ex_rd));
    pc = 1; ie = 1; ifl = 0; xe = 1; xf = 0; me = 1; mf = 0; we = 1; fev = 0;
    if (dm) begin
      pc = 0; ie = 0; xe = 0; me = 0; we = 0;
    end else if (m_frozen > 0 || (br && im)) begin
      pc = 0; ie = 0; xe = 0; mf = 1;
    end else if (br) begin
      ifl = 1; xf = 1; fev = 1;
    end else if (lu) begin
      pc = 0; ie = 0; xf = 1;
    end else if (im) begin
      pc = 0; ifl = 1;
    end
    e.ctrl  = {pc, ie, ifl, xe, xf, me, mf, we, (m_frozen > 0)};
    e.stall = m_stall;
    e.flush = m_flush;
    e.cyc   = cyc;
    q.push_back(e);
    cyc++;
    if (m_frozen > 0) begin
      if (!dm) m_frozen--;
    end else if (xe && !xf && v && mu && LAT > 1) begin
      m_frozen = LAT - 1;
    end
    if (xe) begin
      if (xf || !v) begin m_ex_rd = 0; m_ex_mem = 0; end
      else begin m_ex_rd = rd; m_ex_mem = mr; end
    end
    if (clr) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (!pc && m_stall < CMAX) m_stall++;
      if (fev && m_flush < CMAX) m_flush++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_now(input string name);
    chk({name, "_ctrl"}, cyc, int'(dut_ctrl()), int'(9'b110101010));
    chk({name, "_stall"}, cyc, int'(bus.stall_cnt), 0);
    chk({name, "_flush"}, cyc, int'(bus.flush_cnt), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctrl", e.cyc, int'(dut_ctrl()), int'(e.ctrl));
        chk("stall_cnt", e.cyc, int'(bus.stall_cnt), e.stall);
        chk("flush_cnt", e.cyc, int'(bus.flush_cnt), e.flush);
      end
    end
  end

  initial begin : stim
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_now("reset");
    #10;
    rst_n = 1'b1;

    // Load-use on x5, then the held instruction proceeds; x0 never hazards.
    step(1, 3, 0, 2'b00, 5, 1, 0, 0, 0, 0, 0);
    step(1, 5, 0, 2'b01, 6, 0, 0, 0, 0, 0, 0);
    step(1, 5, 0, 2'b01, 6, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 2'b01, 7, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Multi-cycle op: three frozen cycles.
    step(1, 1, 2, 2'b11, 7, 0, 1, 0, 0, 0, 0);
    idle(5);
    // Branch in the same cycle as a load-use.
    step(1, 3, 0, 2'b00, 4, 1, 0, 0, 0, 0, 0);
    step(1, 4, 0, 2'b01, 8, 0, 0, 1, 0, 0, 0);
    idle(2);
    // Branch waiting for instruction fetch.
    step(1, 1, 1, 2'b00, 2, 0, 0, 1, 1, 0, 0);
    step(1, 1, 1, 2'b00, 2, 0, 0, 1, 1, 0, 0);
    step(1, 1, 1, 2'b00, 2, 0, 0, 1, 0, 0, 0);
    idle(2);
    // Multi-cycle op with a data-memory wait in the middle.
    step(1, 1, 2, 2'b11, 7, 0, 1, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    idle(4);
    // Counter saturation, then clear.
    for (int i = 0; i < 20; i++) step(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Reset while the multi-cycle op is frozen in EX.
    step(1, 1, 2, 2'b11, 7, 0, 1, 0, 0, 0, 0);
    idle(1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_reset_now("reset_mid_multi");
    model_reset();
    #2;
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 8) != 0, int'($urandom % 4), int'($urandom % 4), 2'($urandom),
           int'($urandom % 4), ($urandom % 10) < 4, ($urandom % 10) == 0,
           ($urandom % 7) == 0, ($urandom % 5) == 0, ($urandom % 10) == 0,
           ($urandom % 60) == 0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Sequential hazard and stall controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB). It generates per-stage enables and flushes from:
- load-use hazards
- taken branches/jumps resolved in EX
- instruction-memory and data-memory wait handshakes
- multi-cycle EX operations of parametrised latency
It keeps its own registered copy of ID/EX destination info and provides saturating performance counters. It sits beside the decoder and drives pipeline-register control in the CPU top.

Parameters:
- REG_AW, 5, register address width.
- MUL_LAT, 4, total EX-occupancy cycles of a multi-cycle op (1..16); 1 disables MULTI.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REG_AW  ID source 1
- id_rs2  in  REG_AW  ID source 2
- id_rs_use  in  2  [0]=rs1 read, [1]=rs2 read
- id_rd  in  REG_AW  ID destination
- id_memread  in  1  ID is a load
- id_multi  in  1  ID is a multi-cycle EX op
- ex_branch_taken  in  1  EX redirects PC (taken B-type, JAL, JALR)
- im_stall  in  1  instruction fetch not complete
- dm_stall  in  1  data access not complete
- perf_clr  in  1  synchronous counter clear
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID loads bubble
- idex_en  out  1  ID/EX register enable
- idex_flush  out  1  ID/EX loads bubble
- exmem_en  out  1  EX/MEM register enable
- exmem_flush  out  1  EX/MEM loads bubble
- memwb_en  out  1  MEM/WB register enable
- busy  out  1  FSM in MULTI
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Reset (rst_n low, async):
  - state=RUN, cnt=0, ex_rd=0, ex_memread=0; stall_cnt=0, flush_cnt=0.
  - During and after reset with idle inputs: all *_en=1, all *_flush=0, busy=0.
- Internal EX tracking: when idex_en=1, ex_rd/ex_memread capture id_rd/id_memread, or 0 if idex_flush=1 or id_valid=0.
- Load-use: asserted when ex_memread=1, ex_rd!=0, id_valid=1, and (id_rs_use[0] && id_rs1==ex_rd) or (id_rs_use[1] && id_rs2==ex_rd). x0 never hazards.
- FSM states RUN and MULTI.
  - RUN->MULTI when idex_en=1, idex_flush=0, id_valid=1, id_multi=1 and MUL_LAT>1; cnt loads MUL_LAT-1.
  - In MULTI, on each cycle with dm_stall=0: cnt decrements; at cnt==1 the next state is RUN.
  - The op therefore occupies EX for exactly MUL_LAT unfrozen cycles, and freeze is asserted for the first MUL_LAT-1.
- Output priority, first match wins, evaluated combinationally each cycle:
  1. dm_stall=1: all *_en=0, no flush. FSM and cnt hold.
  2. MULTI: pc_en=ifid_en=idex_en=0; exmem_flush=1, exmem_en=1, memwb_en=1. Load-use and branch are ignored.
  3. ex_branch_taken and im_stall: pc_en=ifid_en=idex_en=0; exmem_flush=1. The branch waits in EX until im_stall drops.
  4. ex_branch_taken: pc_en=1 (redirect); ifid_flush=1, idex_flush=1. The branch outranks a simultaneous load-use.
  5. load-use: pc_en=0, ifid_en=0, idex_flush=1. Lasts exactly one cycle per load.
  6. im_stall: pc_en=0, ifid_flush=1. Downstream stages advance.
  7. Otherwise: all enables 1, no flush.
- Counters:
  - stall_cnt +1 on every cycle with pc_en=0.
  - flush_cnt +1 on every cycle where case 4 applies.
  - Both saturate at all-ones.
  - perf_clr zeroes both and outranks increment.
- Reset mid-MULTI: FSM returns to RUN immediately; no residual freeze.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum {RUN, MULTI}
  - the default REG_AW
  - a packed struct of stage controls (en/flush per stage) used by the priority logic
- One sub-module, sat_counter (CNT_W, inc, clr), instantiated for stall_cnt and flush_cnt.

Test Plan:
1. lw x5 in EX (ex_memread=1, ex_rd=5); ID add with rs1=5, use=01 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; the next cycle is all-enable. Same with rs1=0 and ex_rd=0 -> no stall.
2. MUL_LAT=4; multi op captured into ID/EX -> busy=1 with pc_en/ifid_en/idex_en=0 and exmem_flush=1 for exactly 3 cycles, then release. stall_cnt advances by 3.
3. ex_branch_taken=1 with load-use asserted in the same cycle -> ifid_flush=idex_flush=1, pc_en=1, flush_cnt +1, no load-use stall.
4. ex_branch_taken=1 with im_stall=1 for 2 cycles -> 2 cycles of frozen front end with exmem_flush=1; redirect and flush occur on cycle 3.
5. MULTI with dm_stall pulsed 2 cycles mid-op (MUL_LAT=4) -> all *_en=0 for those cycles, cnt holds, total freeze = 5 cycles. rst_n low mid-MULTI -> busy=0 asynchronously.
6. CNT_W=4: hold im_stall 20 cycles -> stall_cnt saturates at 15. perf_clr -> both counters read 0 next cycle.
